// File: rtl/hamming_enc_ctrl_p.sv
// Sequencing controller for a bit-serial Hamming encoder datapath of any length N.
// Handles word/bit handshakes, optional inter-frame gap, abort and a completed-frame counter.
module hamming_enc_ctrl_p #(
  parameter int N   = 15,
  parameter int CW  = $clog2(N),
  parameter int GAP = 0,
  parameter int GW  = 8,
  parameter int FCW = 16
) (
  input  logic           CLK,
  input  logic           REST_N,
  input  logic           DEVICE_EN,
  input  logic           ABORT,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic           OUT_READY,
  output logic           OUT_VALID,
  output logic           WRITE_EN,
  output logic           SHIFT_EN,
  output logic           COUNTER_EN,
  output logic [CW-1:0]  COUNT,
  output logic           FRAME_START,
  output logic           FRAME_END,
  output logic           BUSY,
  output logic [FCW-1:0] FRAME_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic [FCW-1:0] frame_reg, frame_next;

  logic ir, ov, we, se, ce;

  always_ff @(posedge CLK or negedge REST_N) begin
    if (!REST_N) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      gap_reg   <= '0;
      frame_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      gap_reg   <= gap_next;
      frame_reg <= frame_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    gap_next   = gap_reg;
    frame_next = frame_reg;
    ir = 1'b0;
    ov = 1'b0;
    we = 1'b0;
    se = 1'b0;
    ce = 1'b0;
    // With DEVICE_EN low every next value defaults to a hold.
    if (DEVICE_EN) begin
      if (ABORT) begin
        ov         = (state_reg == S_SHIFT);
        state_next = S_IDLE;
        count_next = '0;
        gap_next   = '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            ir = 1'b1;
            we = IN_VALID;
            if (IN_VALID) begin
              state_next = S_SHIFT;
              count_next = '0;
            end
          end
          S_SHIFT: begin
            ov = 1'b1;
            se = OUT_READY;
            ce = OUT_READY;
            if (OUT_READY) begin
              if (count_reg != LAST) begin
                count_next = count_reg + 1'b1;
              end else begin
                frame_next = frame_reg + 1'b1;
                count_next = '0;
                // Without a gap the next word loads on the same edge as the last shift.
                if (GAP == 0) begin
                  ir         = 1'b1;
                  we         = IN_VALID;
                  state_next = IN_VALID ? S_SHIFT : S_IDLE;
                end else begin
                  state_next = S_GAP;
                  gap_next   = '0;
                end
              end
            end
          end
          S_GAP: begin
            if (gap_reg == GAP_LAST) begin
              state_next = S_IDLE;
              gap_next   = '0;
            end else begin
              gap_next = gap_reg + 1'b1;
            end
          end
          default: begin
            state_next = S_IDLE;
            count_next = '0;
            gap_next   = '0;
          end
        endcase
      end
    end
  end

  assign IN_READY    = REST_N & ir;
  assign OUT_VALID   = REST_N & ov;
  assign WRITE_EN    = REST_N & we;
  assign SHIFT_EN    = REST_N & se;
  assign COUNTER_EN  = REST_N & ce;
  assign FRAME_START = REST_N & (state_reg == S_SHIFT) & (count_reg == '0);
  assign FRAME_END   = REST_N & (state_reg == S_SHIFT) & (count_reg == LAST);
  assign BUSY        = REST_N & (state_reg != S_IDLE);
  assign COUNT       = count_reg;
  assign FRAME_CNT   = frame_reg;

endmodule

// File: tb/tb_hamming_enc_ctrl_p.sv
// Bench for hamming_enc_ctrl_p: three builds (N15/GAP0/FCW16, N15/GAP4, N31/FCW2) share stimulus
// and are checked every cycle against a frame-level reference model.
module tb_hamming_enc_ctrl_p;
  localparam int NI = 3;

  logic CLK = 1'b0;
  logic REST_N, DEVICE_EN, ABORT, IN_VALID, OUT_READY;
  always #5 CLK = ~CLK;

  // Packed view: {ir, ov, we, se, ce, fs, fe, busy, count[7:0], frame_cnt[15:0]}
  logic [31:0] obs [NI];
  logic [31:0] exp_v [NI];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int PN = (gi == 2) ? 31 : 15;
    localparam int PG = (gi == 1) ? 4 : 0;
    localparam int PF = (gi == 2) ? 2 : 16;
    localparam int PC = $clog2(PN);
    logic ir, ov, we, se, ce, fs, fe, bz;
    logic [PC-1:0] cnt;
    logic [PF-1:0] fc;
    hamming_enc_ctrl_p #(.N(PN), .GAP(PG), .FCW(PF)) u_dut (
      .CLK(CLK), .REST_N(REST_N), .DEVICE_EN(DEVICE_EN), .ABORT(ABORT),
      .IN_VALID(IN_VALID), .IN_READY(ir), .OUT_READY(OUT_READY), .OUT_VALID(ov),
      .WRITE_EN(we), .SHIFT_EN(se), .COUNTER_EN(ce), .COUNT(cnt),
      .FRAME_START(fs), .FRAME_END(fe), .BUSY(bz), .FRAME_CNT(fc)
    );
    assign obs[gi] = {ir, ov, we, se, ce, fs, fe, bz, 8'(cnt), 16'(fc)};
  end

  function automatic int n_of(input int k); return (k == 2) ? 31 : 15; endfunction
  function automatic int g_of(input int k); return (k == 1) ? 4 : 0;   endfunction
  function automatic int f_of(input int k); return (k == 2) ? 2 : 16;  endfunction

  // Model: phase 0 idle, 1 sending bits, 2 waiting out the gap.
  int m_ph[NI], m_idx[NI], m_gap[NI], m_frames[NI];
  int n_ph[NI], n_idx[NI], n_gap[NI], n_frames[NI];

  function automatic void eval_model();
    for (int k = 0; k < NI; k++) begin
      int n, g;
      logic ir, ov, we, se, ce, fs, fe, bz;
      n = n_of(k);
      g = g_of(k);
      if (!REST_N) begin
        m_ph[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_frames[k] = 0;
      end
      n_ph[k] = m_ph[k]; n_idx[k] = m_idx[k]; n_gap[k] = m_gap[k]; n_frames[k] = m_frames[k];
      {ir, ov, we, se, ce} = 5'b0;
      bz = (m_ph[k] != 0);
      fs = (m_ph[k] == 1) && (m_idx[k] == 0);
      fe = (m_ph[k] == 1) && (m_idx[k] == n - 1);
      if (REST_N && DEVICE_EN) begin
        if (ABORT) begin
          ov = (m_ph[k] == 1);
          n_ph[k] = 0; n_idx[k] = 0; n_gap[k] = 0;
        end else if (m_ph[k] == 0) begin
          ir = 1'b1;
          we = IN_VALID;
          if (IN_VALID) begin n_ph[k] = 1; n_idx[k] = 0; end
        end else if (m_ph[k] == 1) begin
          ov = 1'b1;
          se = OUT_READY;
          ce = OUT_READY;
          if (OUT_READY && m_idx[k] < n - 1) n_idx[k] = m_idx[k] + 1;
          else if (OUT_READY) begin
            n_frames[k] = m_frames[k] + 1;
            n_idx[k] = 0;
            if (g == 0) begin
              ir = 1'b1;
              we = IN_VALID;
              n_ph[k] = IN_VALID ? 1 : 0;
            end else begin
              n_ph[k] = 2; n_gap[k] = 0;
            end
          end
        end else begin
          if (m_gap[k] == g - 1) begin n_ph[k] = 0; n_gap[k] = 0; end
          else n_gap[k] = m_gap[k] + 1;
        end
      end
      exp_v[k] = {ir, ov, we, se, ce, fs, fe, bz, 8'(m_idx[k]), 16'(m_frames[k] % (1 << f_of(k)))};
    end
  endfunction

  task automatic settle();
    #2;
    eval_model();
  endtask

  task automatic advance();
    @(posedge CLK);
    for (int k = 0; k < NI; k++) begin
      m_ph[k] = n_ph[k]; m_idx[k] = n_idx[k]; m_gap[k] = n_gap[k]; m_frames[k] = n_frames[k];
    end
    #1;
  endtask

  task automatic test_reset();
    REST_N = 1'b0; DEVICE_EN = 1'b1; ABORT = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL reset inst%0d t=%0t: got %h want %h", k, $time, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    REST_N = 1'b1; IN_VALID = 1'b0;
    settle();
    n_tests++;
    if (obs[0] !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL reset_idle inst0: got %h want %h", obs[0], 32'h8000_0000);
    end
    advance();
  endtask

  task automatic test_single_frame();
    DEVICE_EN = 1'b1; ABORT = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 36; i++) begin
      IN_VALID = (i == 0);
      settle();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL single_frame inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    settle();
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if ({obs[k][24], obs[k][15:0]} !== {1'b0, 16'd1}) begin
        n_fail++;
        $display("FAIL single_frame_done inst%0d: got busy=%b cnt=%0d want busy=0 cnt=1",
                 k, obs[k][24], obs[k][15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    DEVICE_EN = 1'b1; ABORT = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 86; i++) begin
      IN_VALID = (i < 46);
      settle();
      if (i == 46) begin
        n_tests++;
        if (obs[0][15:0] !== 16'd4) begin
          n_fail++;
          $display("FAIL back_to_back_frames inst0: got %0d want 4", obs[0][15:0]);
        end
      end
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL back_to_back inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_gap();
    int gap_len = -1;
    int run = 0;
    bit counting = 0;
    DEVICE_EN = 1'b1; ABORT = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 70; i++) begin
      IN_VALID = (i < 30);
      settle();
      if (counting) begin
        if (obs[1][31]) begin counting = 0; gap_len = run; end
        else if (obs[1][24]) run++;
      end
      if (gap_len < 0 && obs[1][25] && obs[1][28]) begin counting = 1; run = 0; end
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL gap inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    n_tests++;
    if (gap_len !== 4) begin
      n_fail++;
      $display("FAIL gap_length inst1: got %0d want 4", gap_len);
    end
  endtask

  task automatic test_stall_disable();
    int stall_left = 3;
    int dis_left = 2;
    int shifts = 0;
    ABORT = 1'b0;
    for (int i = 0; i < 70; i++) begin
      IN_VALID = (i == 0);
      OUT_READY = 1'b1;
      DEVICE_EN = 1'b1;
      if (m_ph[0] == 1 && m_idx[0] == 7 && stall_left > 0) begin OUT_READY = 1'b0; stall_left--; end
      if (m_ph[0] == 1 && m_idx[0] == 9 && dis_left > 0) begin DEVICE_EN = 1'b0; dis_left--; end
      settle();
      if (i < 30 && obs[0][28]) shifts++;
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL stall_disable inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    n_tests++;
    if (shifts !== 15 || stall_left != 0 || dis_left != 0) begin
      n_fail++;
      $display("FAIL stall_shifts inst0: got %0d shifts (stall_left %0d dis_left %0d) want 15",
               shifts, stall_left, dis_left);
    end
  endtask

  task automatic test_abort_reset();
    logic [15:0] saved;
    bit aborted = 0;
    DEVICE_EN = 1'b1; OUT_READY = 1'b1;
    saved = 16'(m_frames[0]);
    for (int i = 0; i < 20 && !aborted; i++) begin
      IN_VALID = (i == 0);
      ABORT = (m_ph[0] == 1 && m_idx[0] == 5);
      aborted = ABORT;
      settle();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL abort inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    ABORT = 1'b0; IN_VALID = 1'b0;
    settle();
    n_tests++;
    if ({obs[0][24], obs[0][23:16], obs[0][15:0]} !== {1'b0, 8'd0, saved}) begin
      n_fail++;
      $display("FAIL abort_after inst0: got busy=%b count=%0d frames=%0d want 0/0/%0d",
               obs[0][24], obs[0][23:16], obs[0][15:0], saved);
    end
    advance();
    for (int i = 0; i < 9; i++) begin
      IN_VALID = (i == 0);
      settle();
      advance();
    end
    REST_N = 1'b0;
    settle();
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (obs[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid_frame inst%0d: got %h want 00000000", k, obs[k]);
      end
    end
    advance();
    REST_N = 1'b1;
  endtask

  task automatic test_wrap();
    DEVICE_EN = 1'b1; ABORT = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 196; i++) begin
      IN_VALID = (i < 156);
      settle();
      if (i == 156) begin
        n_tests++;
        if (obs[2][15:0] !== 16'd1) begin
          n_fail++;
          $display("FAIL wrap inst2: got %0d want 1", obs[2][15:0]);
        end
      end
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL wrap_seq inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      REST_N    = ($urandom_range(499) != 0);
      DEVICE_EN = ($urandom_range(9) != 0);
      ABORT     = ($urandom_range(39) == 0);
      IN_VALID  = $urandom_range(1) == 1;
      OUT_READY = ($urandom_range(3) != 0);
      settle();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", k, i, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    REST_N = 1'b1; ABORT = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_ph[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_frames[k] = 0;
    end
    REST_N = 1'b0; DEVICE_EN = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_stall_disable();
    test_abort_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_enc_ctrl_p.md
Name: hamming_enc_ctrl_p

Overview:
- Parametrised successor to the fixed (15,11) encoding controller; sequences a bit-serial Hamming encoder datapath for any codeword length N.
- Owns its bit counter, adds valid/ready handshakes on the word input and serial output, optional inter-frame gap, abort and a completed-frame counter.
- Sits between the word source and the encoder shift register; drives WRITE_EN/SHIFT_EN to the datapath.

Parameters:
- N, 15, codeword length in bits (N >= 3).
- CW, $clog2(N), width of COUNT.
- GAP, 0, idle cycles inserted after each frame (0 = back-to-back allowed).
- GW, 8, width of the gap counter (GAP < 2**GW).
- FCW, 16, width of FRAME_CNT.

Ports:
- CLK  input  1  clock, rising edge.
- REST_N  input  1  asynchronous active-low reset.
- DEVICE_EN  input  1  global enable; low freezes all state.
- ABORT  input  1  synchronous abort of the current frame.
- IN_VALID  input  1  source has a data word.
- IN_READY  output  1  controller accepts a word this cycle.
- OUT_READY  input  1  sink accepts a serial bit this cycle.
- OUT_VALID  output  1  serial bit on the datapath output is valid.
- WRITE_EN  output  1  datapath loads word and computes parity.
- SHIFT_EN  output  1  datapath shifts one bit.
- COUNTER_EN  output  1  COUNT advances this cycle.
- COUNT  output  CW  index of the bit currently presented, 0..N-1.
- FRAME_START  output  1  first bit of a frame is presented.
- FRAME_END  output  1  last bit of a frame is presented.
- BUSY  output  1  state is not IDLE.
- FRAME_CNT  output  FCW  completed frames, wraps modulo 2**FCW.

Behaviour:
- Reset (REST_N=0, asynchronous): state IDLE; COUNT=0; gap counter=0; FRAME_CNT=0. All 1-bit outputs 0 while in reset.
- States: IDLE, SHIFT, GAP.
- All handshake outputs are combinational from state, COUNT and inputs. A "shift" is SHIFT_EN=1 at a clock edge.
- DEVICE_EN=0: IN_READY, OUT_VALID, WRITE_EN, SHIFT_EN and COUNTER_EN are all 0. State, COUNT, gap counter and FRAME_CNT hold. BUSY, COUNT and FRAME_CNT still reflect the held state.
- ABORT=1 (DEVICE_EN=1): highest priority. Next state IDLE, COUNT->0, gap counter->0, FRAME_CNT unchanged. IN_READY, WRITE_EN and SHIFT_EN are 0 that cycle.
- IDLE:
  - IN_READY=1.
  - WRITE_EN = IN_VALID.
  - On accept (IN_VALID & IN_READY): next state SHIFT, COUNT=0.
- SHIFT:
  - OUT_VALID=1.
  - SHIFT_EN = COUNTER_EN = OUT_READY.
  - FRAME_START = (COUNT==0); FRAME_END = (COUNT==N-1).
  - On a shift with COUNT<N-1: COUNT+1.
  - On a shift with COUNT==N-1: FRAME_CNT+1, COUNT->0.
    - If GAP==0: IN_READY=1 in that same cycle; WRITE_EN = IN_VALID. If a word is accepted, stay in SHIFT (zero-bubble back-to-back); otherwise go to IDLE.
    - If GAP>0: IN_READY=0; go to GAP with gap counter=0.
  - OUT_READY=0 stalls: COUNT and state hold, OUT_VALID stays 1.
- GAP:
  - All handshakes 0.
  - Gap counter increments each enabled cycle.
  - When gap counter==GAP-1: next state IDLE.
  - Exactly GAP enabled cycles are spent in GAP.
- WRITE_EN and SHIFT_EN are never both 1 except at the back-to-back boundary (last-bit shift plus new load). The datapath gives load priority over shift.
- COUNT never exceeds N-1. No state is reachable other than the three listed; an illegal encoding recovers to IDLE.

Test Plan:
- Reset, then DEVICE_EN=1, IN_VALID pulse, OUT_READY=1, N=15, GAP=0 -> WRITE_EN for 1 cycle, then 15 SHIFT_EN cycles with COUNT 0..14, FRAME_START at COUNT 0, FRAME_END at 14, FRAME_CNT=1, BUSY falls after the last shift.
- IN_VALID held high, GAP=0 -> WRITE_EN coincides with the COUNT=14 shift, next cycle COUNT=0 in SHIFT with no bubble; 3 frames take 1+45 cycles and FRAME_CNT=3.
- GAP=4, IN_VALID high -> after FRAME_END, exactly 4 cycles with BUSY=1 and IN_READY=0, then IN_READY=1 in IDLE.
- OUT_READY low for 3 cycles at COUNT=7, then DEVICE_EN low for 2 cycles at COUNT=9 -> COUNT holds at 7 then 9, OUT_VALID=1 during the OUT_READY stall and 0 during the disable, frame completes after 15 total shifts.
- ABORT at COUNT=5 -> next cycle IDLE, COUNT=0, FRAME_CNT unchanged; REST_N pulsed low mid-frame -> outputs 0 immediately, FRAME_CNT=0.
- N=31, CW=5 build -> COUNT runs 0..30, FRAME_END at 30; FCW=2 build, 5 frames -> FRAME_CNT wraps to 1.
